// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: load-use, EX redirects and
// data-memory wait states, with perf counters and a memory-wait watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 id_ex_mem_read,
  input  logic                 ex_redirect,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 cnt_clear,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 mem_wb_flush,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 mem_timeout_err
);

  localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              load_use, mem_hold, flush_act;

  assign mem_hold = dmem_req & ~dmem_ready;
  assign load_use = id_ex_mem_read & (id_ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == id_ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == id_ex_rd)));

  // Outputs are forced low while rst is high so stage registers see no stray controls.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    flush_act    = 1'b0;
    if (rst) begin
      flush_act = 1'b0;
    end else if ((state_q == ERROR) || mem_hold) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_act   = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          // wcnt counts hold cycles already spent waiting before this one.
          if ((MEM_TIMEOUT != 0) && (wcnt_q == WCNT_W'(MEM_TIMEOUT))) begin
            state_d = ERROR;
          end
        end
      end
      default: state_d = ERROR;
    endcase
    err_d = err_q | (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clear),
    .inc (pc_stall),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clear),
    .inc (flush_act),
    .cnt (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int MAXC    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    rs1 = '0, rs2 = '0, idExRd = '0;
  logic          usesRs1 = 1'b0, usesRs2 = 1'b0, idExMemRead = 1'b0;
  logic          exRedirect = 1'b0, dmemReq = 1'b0, dmemReady = 1'b0, cntClear = 1'b0;
  logic          pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush;
  logic [CW-1:0] stallObs, flushObs;
  logic          errObs;
  logic [6:0]    ctrlObs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int consHold = 0;
  int stallExp = 0;
  int flushExp = 0;
  bit mErr     = 1'b0;

  always #5 clk = ~clk;

  assign ctrlObs = {pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush};

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (rs1),
    .id_rs2          (rs2),
    .id_uses_rs1     (usesRs1),
    .id_uses_rs2     (usesRs2),
    .id_ex_rd        (idExRd),
    .id_ex_mem_read  (idExMemRead),
    .ex_redirect     (exRedirect),
    .dmem_req        (dmemReq),
    .dmem_ready      (dmemReady),
    .cnt_clear       (cntClear),
    .pc_stall        (pcStall),
    .if_id_stall     (ifIdStall),
    .if_id_flush     (ifIdFlush),
    .id_ex_stall     (idExStall),
    .id_ex_flush     (idExFlush),
    .ex_mem_stall    (exMemStall),
    .mem_wb_flush    (memWbFlush),
    .stall_cycles    (stallObs),
    .flush_events    (flushObs),
    .mem_timeout_err (errObs)
  );

  // Expected control vector {pc, ifidS, ifidF, idexS, idexF, exmemS, memwbF}.
  function automatic logic [6:0] expCtrl();
    bit hold, lu;
    if (rst) return 7'b0;
    hold = dmemReq && !dmemReady;
    lu = idExMemRead && (idExRd != 0) &&
         ((usesRs1 && rs1 == idExRd) || (usesRs2 && rs2 == idExRd));
    if (mErr || hold) return 7'b1101011;
    if (exRedirect)   return 7'b0010100;
    if (lu)           return 7'b1100100;
    return 7'b0;
  endfunction

  task automatic modelReset();
    consHold = 0;
    stallExp = 0;
    flushExp = 0;
    mErr     = 1'b0;
  endtask

  task automatic clearInputs();
    rs1 = '0; rs2 = '0; idExRd = '0;
    usesRs1 = 1'b0; usesRs2 = 1'b0; idExMemRead = 1'b0;
    exRedirect = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0; cntClear = 1'b0;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic [6:0] e;
    bit hold;
    e = expCtrl();
    hold = dmemReq && !dmemReady;
    @(posedge clk);
    if (!mErr) begin
      if (hold) begin
        consHold++;
        if (TIMEOUT != 0 && consHold > TIMEOUT) mErr = 1'b1;
      end else begin
        consHold = 0;
      end
    end
    if (cntClear) begin
      stallExp = 0;
      flushExp = 0;
    end else begin
      if (e[6] && stallExp < MAXC) stallExp++;
      if (e == 7'b0010100 && flushExp < MAXC) flushExp++;
    end
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    #1 rst = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    dmemReq = 1'b1; idExMemRead = 1'b1; idExRd = 5'd3; rs1 = 5'd3; usesRs1 = 1'b1;
    #1 rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (ctrlObs !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl obs=%b exp=%b", ctrlObs, 7'b0);
    end
    checks++;
    if ({stallObs, flushObs, errObs} !== '0) begin
      errors++; $display("[TB] FAIL reset_state obs=%h/%h/%b exp=0/0/0", stallObs, flushObs, errObs);
    end
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    idExMemRead = 1'b1; idExRd = 5'd5; rs1 = 5'd5; usesRs1 = 1'b1; rs2 = 5'd1; usesRs2 = 1'b1;
    #1;
    checks++;
    if (ctrlObs !== expCtrl() || ctrlObs !== 7'b1100100) begin
      errors++; $display("[TB] FAIL load_use obs=%b exp=%b", ctrlObs, expCtrl());
    end
    tick();
    idExMemRead = 1'b0;
    #1;
    checks++;
    if (ctrlObs !== expCtrl()) begin
      errors++; $display("[TB] FAIL load_use_release obs=%b exp=%b", ctrlObs, expCtrl());
    end
    checks++;
    if (stallObs !== CW'(stallExp)) begin
      errors++; $display("[TB] FAIL load_use_stallcnt obs=%0d exp=%0d", stallObs, stallExp);
    end
    idExMemRead = 1'b1; idExRd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++;
    if (ctrlObs !== 7'b0) begin
      errors++; $display("[TB] FAIL load_use_x0 obs=%b exp=%b", ctrlObs, 7'b0);
    end
    idExRd = 5'd9; rs1 = 5'd2; rs2 = 5'd9; usesRs2 = 1'b0;
    #1;
    checks++;
    if (ctrlObs !== expCtrl()) begin
      errors++; $display("[TB] FAIL load_use_unused_rs2 obs=%b exp=%b", ctrlObs, expCtrl());
    end
    tick();
    clearInputs();
  endtask

  task automatic test_redirect();
    cntClear = 1'b1;
    tick();
    cntClear = 1'b0;
    exRedirect = 1'b1; idExMemRead = 1'b1; idExRd = 5'd7; rs1 = 5'd7; usesRs1 = 1'b1;
    #1;
    checks++;
    if (ctrlObs !== expCtrl() || ctrlObs !== 7'b0010100) begin
      errors++; $display("[TB] FAIL redirect_ctrl obs=%b exp=%b", ctrlObs, expCtrl());
    end
    tick();
    exRedirect = 1'b0; idExMemRead = 1'b0;
    #1;
    checks++;
    if (flushObs !== CW'(flushExp) || flushObs !== CW'(1)) begin
      errors++; $display("[TB] FAIL redirect_flushcnt obs=%0d exp=%0d", flushObs, flushExp);
    end
    checks++;
    if (stallObs !== CW'(stallExp)) begin
      errors++; $display("[TB] FAIL redirect_stallcnt obs=%0d exp=%0d", stallObs, stallExp);
    end
    clearInputs();
  endtask

  task automatic test_mem_wait();
    cntClear = 1'b1;
    tick();
    cntClear = 1'b0;
    dmemReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmemReady = (i == 3);
      #1;
      checks++;
      if (ctrlObs !== expCtrl()) begin
        errors++; $display("[TB] FAIL mem_wait_ctrl cyc=%0d obs=%b exp=%b", i, ctrlObs, expCtrl());
      end
      tick();
    end
    clearInputs();
    #1;
    checks++;
    if (ctrlObs !== 7'b0 || stallObs !== CW'(stallExp) || stallObs !== CW'(3)) begin
      errors++; $display("[TB] FAIL mem_wait_after ctrl=%b stall=%0d exp=%0d", ctrlObs, stallObs, stallExp);
    end
    dmemReq = 1'b1; dmemReady = 1'b1;
    #1;
    checks++;
    if (ctrlObs !== 7'b0) begin
      errors++; $display("[TB] FAIL mem_ready_first obs=%b exp=%b", ctrlObs, 7'b0);
    end
    tick();
    clearInputs();
  endtask

  task automatic test_timeout();
    dmemReq = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ctrlObs !== expCtrl() || errObs !== mErr) begin
        errors++; $display("[TB] FAIL timeout_cyc%0d ctrl=%b exp=%b err=%b exp=%b", i, ctrlObs, expCtrl(), errObs, mErr);
      end
      tick();
    end
    clearInputs();
    #1;
    checks++;
    if (errObs !== 1'b1 || ctrlObs !== 7'b1101011) begin
      errors++; $display("[TB] FAIL timeout_sticky err=%b ctrl=%b exp=1/1101011", errObs, ctrlObs);
    end
    doReset();
    checks++;
    if (errObs !== 1'b0 || ctrlObs !== 7'b0) begin
      errors++; $display("[TB] FAIL timeout_reset err=%b ctrl=%b exp=0/0000000", errObs, ctrlObs);
    end
  endtask

  task automatic test_redirect_in_hold();
    dmemReq = 1'b1; dmemReady = 1'b0; exRedirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dmemReady = (i == 2);
      #1;
      checks++;
      if (ctrlObs !== expCtrl()) begin
        errors++; $display("[TB] FAIL redir_hold cyc=%0d obs=%b exp=%b", i, ctrlObs, expCtrl());
      end
      tick();
    end
    clearInputs();
    dmemReq = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (ctrlObs !== 7'b0 || errObs !== 1'b0 || stallObs !== '0) begin
      errors++; $display("[TB] FAIL async_reset ctrl=%b err=%b stall=%0d exp=0", ctrlObs, errObs, stallObs);
    end
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    idExMemRead = 1'b1; idExRd = 5'd4; rs2 = 5'd4; usesRs2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (stallObs !== CW'(stallExp)) begin
        errors++; $display("[TB] FAIL sat_cyc%0d obs=%0d exp=%0d", i, stallObs, stallExp);
      end
    end
    checks++;
    if (stallObs !== CW'(MAXC)) begin
      errors++; $display("[TB] FAIL sat_held obs=%0d exp=%0d", stallObs, MAXC);
    end
    cntClear = 1'b1;
    tick();
    cntClear = 1'b0;
    checks++;
    if (stallObs !== '0) begin
      errors++; $display("[TB] FAIL sat_clear obs=%0d exp=0", stallObs);
    end
    clearInputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      idExRd = 5'($urandom_range(0, 3));
      usesRs1 = 1'($urandom);
      usesRs2 = 1'($urandom);
      idExMemRead = 1'($urandom);
      exRedirect = ($urandom_range(0, 3) == 0);
      dmemReq = 1'($urandom);
      dmemReady = ($urandom_range(0, 3) != 0);
      cntClear = ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (ctrlObs !== expCtrl()) begin
        errors++; $display("[TB] FAIL rand_ctrl cyc=%0d obs=%b exp=%b", i, ctrlObs, expCtrl());
      end
      tick();
      checks++;
      if (stallObs !== CW'(stallExp) || flushObs !== CW'(flushExp) || errObs !== mErr) begin
        errors++; $display("[TB] FAIL rand_state cyc=%0d stall=%0d/%0d flush=%0d/%0d err=%b/%b",
                           i, stallObs, stallExp, flushObs, flushExp, errObs, mErr);
      end
      if (mErr) doReset();
    end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_redirect_in_hold();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
